// File: rtl/inst_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, ALU op codes
// (same values ALU control emits), request classes and the FIFO entry layout.
package inst_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b01010;
    localparam logic [4:0] ALU_SRA  = 5'b01011;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10001;
    localparam logic [4:0] ALU_BLT  = 5'b10010;
    localparam logic [4:0] ALU_BGE  = 5'b10011;
    localparam logic [4:0] ALU_BLTU = 5'b10100;
    localparam logic [4:0] ALU_BGEU = 5'b10101;
    localparam logic [4:0] ALU_SLT  = 5'b10110;
    localparam logic [4:0] ALU_SLTU = 5'b10111;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } inst_class_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } fifo_entry_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
    } alu_map_t;

    // R/I arithmetic mapping from ALU op code to funct3/funct7.
    function automatic alu_map_t alu_map(input logic [4:0] op);
        alu_map_t m;
        m = '{ok: 1'b1, f3: 3'b000, f7: F7_ZERO};
        case (op)
            ALU_ADD:  m.f3 = 3'b000;
            ALU_SUB:  begin m.f3 = 3'b000; m.f7 = F7_ALT; end
            ALU_SLL:  m.f3 = 3'b001;
            ALU_SLT:  m.f3 = 3'b010;
            ALU_SLTU: m.f3 = 3'b011;
            ALU_XOR:  m.f3 = 3'b100;
            ALU_SRL:  m.f3 = 3'b101;
            ALU_SRA:  begin m.f3 = 3'b101; m.f7 = F7_ALT; end
            ALU_OR:   m.f3 = 3'b110;
            ALU_AND:  m.f3 = 3'b111;
            default:  m.ok = 1'b0;
        endcase
        return m;
    endfunction

    // True when v, read as signed, is representable in nbits two's complement.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (nbits - 1);
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry FIFO with registered occupancy; full/empty derive only from state.
module inst_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    logic [1:0][W-1:0] mem_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: maps an ALU-op style request to a legal 32-bit word
// and queues {word, addr} for the instruction-memory loader.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [4:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_addr,
    output logic        err_illegal,
    output logic [7:0]  err_count
);
    logic        legal;
    logic [31:0] word;
    logic [2:0]  bf3;
    logic        bok;
    alu_map_t    m;
    logic        accept, push, pop, full, empty;
    logic [31:0] next_addr_q;
    logic        err_illegal_q;
    logic [7:0]  err_count_q;
    fifo_entry_t wentry, rentry;

    always_comb begin
        legal = 1'b0;
        word  = 32'h0;
        m     = alu_map(req_alu_op);
        bok   = 1'b1;
        bf3   = 3'b000;
        case (req_alu_op)
            ALU_BEQ:  bf3 = 3'b000;
            ALU_BNE:  bf3 = 3'b001;
            ALU_BLT:  bf3 = 3'b100;
            ALU_BGE:  bf3 = 3'b101;
            ALU_BLTU: bf3 = 3'b110;
            ALU_BGEU: bf3 = 3'b111;
            default:  bok = 1'b0;
        endcase
        case (req_class)
            CLS_R: begin
                legal = m.ok;
                word  = {m.f7, req_rs2, req_rs1, m.f3, req_rd, OP_R};
            end
            CLS_I: begin
                if (m.f3 == 3'b001 || m.f3 == 3'b101) begin
                    // Shifts take shamt from imm[4:0]; imm[11:5] is replaced by funct7.
                    legal = m.ok;
                    word  = {m.f7, req_imm[4:0], req_rs1, m.f3, req_rd, OP_I};
                end else begin
                    legal = m.ok && (req_alu_op != ALU_SUB) && sext_fits(req_imm, 12);
                    word  = {req_imm[11:0], req_rs1, m.f3, req_rd, OP_I};
                end
            end
            CLS_LOAD: begin
                legal = (req_alu_op == ALU_ADD) && sext_fits(req_imm, 12) &&
                        (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            end
            CLS_STORE: begin
                legal = (req_alu_op == ALU_ADD) && sext_fits(req_imm, 12) &&
                        (req_funct3 inside {3'b000, 3'b001, 3'b010});
                word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                legal = bok && !req_imm[0] && sext_fits(req_imm, 13);
                word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, bf3,
                         req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            CLS_LUI: begin
                legal = 1'b1;
                word  = {req_imm[31:12], req_rd, OP_LUI};
            end
            CLS_AUIPC: begin
                legal = (req_alu_op == ALU_ADD);
                word  = {req_imm[31:12], req_rd, OP_AUIPC};
            end
            CLS_JAL: begin
                legal = (req_alu_op == ALU_ADD) && !req_imm[0] && sext_fits(req_imm, 21);
                word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            CLS_JALR: begin
                legal = (req_alu_op == ALU_ADD) && sext_fits(req_imm, 12);
                word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            end
            default: legal = 1'b0;
        endcase
    end

    // req_ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign req_ready = !full;
    assign accept    = req_valid && req_ready && !clear;
    assign push      = accept && legal;
    assign pop       = inst_valid && inst_ready;
    assign wentry    = '{word: word, addr: next_addr_q};

    inst_fifo2 #(.W(64)) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty)
    );

    assign inst_valid  = !empty;
    assign inst_word   = rentry.word;
    assign inst_addr   = rentry.addr;
    assign err_illegal = err_illegal_q;
    assign err_count   = err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_addr_q   <= BASE_ADDR;
            err_illegal_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else if (clear) begin
            next_addr_q   <= BASE_ADDR;
            err_illegal_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            err_illegal_q <= accept && !legal;
            if (accept && !legal && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
            if (push)
                next_addr_q <= next_addr_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push expected {word, addr};
// a negedge monitor pops and compares whenever the FIFO head is consumed.
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_class = '0;
    logic [4:0]  req_alu_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_word, inst_addr;
    logic        err_illegal;
    logic [7:0]  err_count;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;
    logic [31:0] exp_addr = 32'h0;
    int          exp_err = 0;

    inst_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_alu_op(req_alu_op), .req_funct3(req_funct3),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_addr(inst_addr),
        .err_illegal(err_illegal), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h expected=none", inst_word);
            end else begin
                mon_e = sb_q.pop_front();
                chk("inst_word", inst_word, mon_e[63:32]);
                chk("inst_addr", inst_addr, mon_e[31:0]);
            end
        end
    end

    task automatic setreq(input logic [3:0] cls, input logic [4:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        req_class = cls; req_alu_op = op; req_funct3 = f3;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    task automatic expect_word(input logic [31:0] w);
        sb_q.push_back({w, exp_addr});
        exp_addr = exp_addr + 32'd4;
    endtask

    // Issue one request, wait (bounded) for acceptance, then check the error outputs.
    task automatic send(input logic [3:0] cls, input logic [4:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic ok, input logic [31:0] w);
        int n;
        setreq(cls, op, f3, rd, rs1, rs2, imm);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (ok) expect_word(w);
        else if (exp_err < 255) exp_err++;
        chk("err_illegal", {31'b0, err_illegal}, {31'b0, !ok});
        chk("err_count", {24'b0, err_count}, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_word", inst_word, 0);
        chk("rst_inst_addr", inst_addr, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_err_count", err_count, 0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b1;

        send(4'd0, 5'b00000, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
        chk("latency_valid", inst_valid, 1);
        send(4'd1, 5'b01011, 3'b000, 5'd5, 5'd6, 5'd9, 32'd7, 1, 32'h40735293);
        send(4'd1, 5'b00001, 3'b000, 5'd5, 5'd6, 5'd0, 32'd7, 0, 32'h0);
        send(4'd4, 5'b10010, 3'b000, 5'd7, 5'd1, 5'd2, -32'sd8, 1, 32'hFE20CCE3);
        send(4'd4, 5'b10010, 3'b000, 5'd7, 5'd1, 5'd2, 32'd3, 0, 32'h0);
        send(4'd4, 5'b10000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd4094, 1, 32'h7E000FE3);
        send(4'd4, 5'b10000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd4096, 0, 32'h0);
        send(4'd7, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF);
        send(4'd7, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 0, 32'h0);
        send(4'd5, 5'b10101, 3'b000, 5'd10, 5'd3, 5'd4, 32'h12345000, 1, 32'h12345537);
        send(4'd2, 5'b00000, 3'b010, 5'd5, 5'd2, 5'd0, 32'd16, 1, 32'h01012283);
        send(4'd2, 5'b00000, 3'b011, 5'd5, 5'd2, 5'd0, 32'd16, 0, 32'h0);
        send(4'd3, 5'b00000, 3'b010, 5'd0, 5'd2, 5'd5, -32'sd4, 1, 32'hFE512E23);
        send(4'd1, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFF00093);
        send(4'd1, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2047, 1, 32'h7FF00093);
        send(4'd1, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'h0);
        send(4'd0, 5'b00100, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32'h0);
        send(4'd9, 5'b00000, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain1", sb_q.size(), 0);

        // Back-to-back with the consumer stalled: fill, observe backpressure, release.
        inst_ready = 1'b0;
        setreq(4'd0, 5'b00000, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid = 1'b1;
        expect_word(32'h002081B3);
        @(posedge clk); #1;
        chk("ready_one", req_ready, 1);
        setreq(4'd0, 5'b00001, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word(32'h402081B3);
        @(posedge clk); #1;
        chk("ready_full", req_ready, 0);
        chk("hold_word", inst_word, 32'h002081B3);
        setreq(4'd0, 5'b00011, 3'b000, 5'd4, 5'd5, 5'd6, 32'd0);
        expect_word(32'h0062E233);
        @(posedge clk); #1;
        chk("ready_still_full", req_ready, 0);
        chk("hold_word2", inst_word, 32'h002081B3);
        chk("hold_addr2", inst_addr, exp_addr - 32'd12);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_pop", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain2", sb_q.size(), 0);

        for (int i = 0; i < 300; i++)
            send(4'd12, 5'b00000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'h0);
        chk("err_sat", err_count, 255);

        // Clear wins over a simultaneous legal request.
        setreq(4'd0, 5'b00000, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        req_valid = 1'b0;
        exp_err = 0;
        exp_addr = 32'h0;
        chk("clear_err_count", err_count, 0);
        chk("clear_no_push", inst_valid, 0);
        send(4'd5, 5'b00000, 3'b000, 5'd10, 5'd0, 5'd0, 32'h12345000, 1, 32'h12345537);
        repeat (3) @(posedge clk);
        #1;
        chk("drain3", sb_q.size(), 0);

        // Asynchronous reset with words queued.
        inst_ready = 1'b0;
        send(4'd0, 5'b00000, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
        send(4'd0, 5'b00001, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3);
        chk("pre_reset_valid", inst_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", inst_valid, 0);
        chk("areset_word", inst_word, 0);
        chk("areset_addr", inst_addr, 0);
        chk("areset_ready", req_ready, 1);
        sb_q.delete();
        exp_addr = 32'h0;
        exp_err = 0;
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b1;
        send(4'd7, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_final", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the RISC-V single-cycle CPU lab: the inverse of the ALU control decode. It accepts an operation request (instruction class, 5-bit ALU operation code, registers, immediate) over a valid/ready handshake and emits the legal 32-bit RV32I instruction word. The emitted word decodes back to the same ALU operation. Legal words are buffered in a 2-entry FIFO together with an auto-incrementing instruction-memory address, feeding the testbench program loader and the instruction-memory write port.

## Interface
- BASE_ADDR, 32'h0000_0000, address of the first emitted word; always a multiple of 4.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- clear  in  1  synchronous; flushes the FIFO, reloads the address to BASE_ADDR and zeroes err_count.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9–15 illegal.
- req_alu_op  in  5  ALU operation code, same encoding the ALU control emits.
- req_funct3  in  3  width select; used only by LOAD and STORE.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  32  sign-extended immediate; the byte offset for BRANCH and JAL.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  consumer pops the head on an edge where inst_valid && inst_ready.
- inst_word  out  32  encoded instruction at the FIFO head.
- inst_addr  out  32  address of the head word.
- err_illegal  out  1  one-cycle pulse when an accepted request is illegal.
- err_count  out  8  count of illegal requests; saturates at 255.

## Operation
- R class, alu_op mapping:
  - 00000 ADD: funct3 000, funct7 0000000.
  - 00001 SUB: funct3 000, funct7 0100000.
  - 01101 SLL: funct3 001.
  - 10110 SLT: funct3 010.
  - 10111 SLTU: funct3 011.
  - 00110 XOR: funct3 100.
  - 01010 SRL: funct3 101, funct7 0000000.
  - 01011 SRA: funct3 101, funct7 0100000.
  - 00011 OR: funct3 110.
  - 00010 AND: funct3 111.
  - Any other alu_op is illegal.
- I class: the same mapping with opcode 0010011.
  - SUB is illegal.
  - Shifts: shamt = imm[4:0], bits[31:25] = funct7; imm[11:5] is ignored.
  - All other I ops: imm[11:0]. Out of range (imm not within −2048..2047) is illegal.
- LOAD (0000011): alu_op must be 00000; funct3 ∈ {000,001,010,100,101}; I-type imm.
- STORE (0100011): alu_op must be 00000; funct3 ∈ {000,001,010}; S-type imm split.
- BRANCH (1100011): alu_op 10000..10101 maps to funct3 000,001,100,101,110,111. B-type imm. Illegal if imm[0]=1 or imm not within −4096..4094.
- LUI (0110111) and AUIPC (0010111): word[31:12] = imm[31:12].
  - LUI ignores alu_op.
  - AUIPC requires alu_op 00000.
- JAL (1101111): alu_op must be 00000. J-type imm; illegal if imm[0]=1 or imm is out of the 21-bit range.
- JALR (1100111): alu_op must be 00000; funct3 000; I-type imm.
- Unused register fields in a word are zero.
- An illegal request is still accepted: it is dropped, pulses err_illegal, and increments err_count. It does not write the FIFO or advance the address.
- A legal request pushes {word, addr}; the next address register then advances by 4, wrapping mod 2^32.

## Timing
- Reset values: req_ready=1, inst_valid=0, inst_word=0, inst_addr=0, err_illegal=0, err_count=0. The internal next address is BASE_ADDR.
- Latency: a request accepted at edge N into an empty FIFO gives inst_valid=1 in the cycle after edge N (one-cycle registered latency).
- Throughput: one request per cycle while the FIFO has space.
- req_ready = (count < 2), registered state only. There is no combinational path from inst_ready to req_ready.
  - When full, a pop in the same cycle does not allow a push in that cycle.
- A simultaneous push and pop with count=1 leaves count=1; the head advances to the new word.
- inst_word and inst_addr are held stable while inst_valid && !inst_ready.
- clear has priority over push and pop in the same cycle; the request on that edge is not accepted.
- Asserting reset_n low mid-transfer immediately empties the FIFO and drives all outputs to their reset values.

## Structure
- Package inst_enc_pkg holds:
  - opcode constants;
  - ALU operation codes, shared with ALU control;
  - class codes;
  - funct7 constants.
- Sub-module inst_fifo2: a 2-entry, 64-bit-wide FIFO with registered count, full and empty.
- Encode logic is combinational from the request fields; legality is computed in the same cycle.

## Test plan
- After reset, send R ADD x3,x1,x2 (class 0, alu_op 00000) → inst_word 32'h002081B3, inst_addr BASE_ADDR, inst_valid one cycle later.
- Send I SRA shift x5,x6 by 7 (class 1, alu_op 01011, imm 7) → inst_word 32'h40735293. Send I SUB → err_illegal pulse, err_count=1, no FIFO push.
- Send BRANCH BLT x1,x2 with imm −8 (alu_op 10010) → 32'hFE20CCE3. Send the same request with imm 3 → illegal.
- Hold inst_ready=0 and send 3 back-to-back requests → req_ready drops after the 2nd. Release inst_ready → addresses BASE, BASE+4, BASE+8 in order.
- Send JAL x1 with imm 2048 → 32'h001000EF. Then send LUI x10 with imm 32'h12345000 → 32'h12345537.
- Send 300 illegal requests → err_count holds at 255. Pulse clear → err_count=0 and the next word lands at BASE_ADDR. Assert reset_n low mid-stream → inst_valid=0 immediately.
